inst_fetch_queue: RTL

Instruction fetch stage directly upstream of the arithmetic machine's decode/execute datapath. Owns the fetch PC, issues word-aligned read requests to an instruction memory with variable latency, and buffers returned instructions in a small in-order queue. The queue presents `inst`/`inst_pc` to the downstream stage through a valid/ready handshake and supports a one-cycle redirect/flush for later branch support.

---
 rtl/inst_fetch_queue_pkg.sv | 31 +++
 rtl/inst_fetch_queue_if.sv | 36 +++
 rtl/inst_fetch_queue_fifo.sv | 76 +++++++
 rtl/inst_fetch_queue.sv | 139 +++++++++++++
 4 files changed

// File: rtl/inst_fetch_queue_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : fetch_pkg
//  Description : Shared constants, queue entry type and a PC alignment
//                helper for the instruction fetch stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    // Default fetch address after reset (word aligned).
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Word address width presented to instruction memory (PC[31:2]).
    localparam int unsigned WORD_ADDR_W = 30;

    // Sequential fetch step in bytes.
    localparam logic [31:0] PC_INCR = 32'd4;

    // One buffered instruction together with the PC it was fetched from.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    // Forces a byte address onto a word boundary.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage
`default_nettype wire

// File: rtl/inst_fetch_queue_if.sv
`default_nettype none
// ============================================================================
//  Interface   : inst_fetch_queue_if
//  Description : Bundles the memory request/response channel, the downstream
//                instruction handshake and the redirect request of the fetch
//                stage.
//  Modports    : master - the fetch stage (drives requests and instructions)
//                slave  - memory plus downstream/branch side
//  Revision    : 1.0 - initial release
// ============================================================================
interface inst_fetch_queue_if;

    logic                             req_valid;
    logic                             req_ready;
    logic [fetch_pkg::WORD_ADDR_W-1:0] req_addr;
    logic                             resp_valid;
    logic [31:0]                      resp_data;
    logic                             inst_valid;
    logic                             inst_ready;
    logic [31:0]                      inst;
    logic [31:0]                      inst_pc;
    logic                             redirect;
    logic [31:0]                      redirect_pc;

    modport master (
        output req_valid, req_addr, inst_valid, inst, inst_pc,
        input  req_ready, resp_valid, resp_data, inst_ready, redirect, redirect_pc
    );

    modport slave (
        input  req_valid, req_addr, inst_valid, inst, inst_pc,
        output req_ready, resp_valid, resp_data, inst_ready, redirect, redirect_pc
    );

endinterface
`default_nettype wire

// File: rtl/inst_fetch_queue_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_fifo
//  Description : Small synchronous FIFO with registered head and a flush
//                that takes priority over push and pop. Head reads as zero
//                while empty.
//  Ports       : clock, reset (async, active-low), flush, push/push_data,
//                pop, head_data, count (current occupancy)
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        do_pop   = pop && (count_q != '0) && !flush;
        // A full FIFO still accepts a push when the head leaves in the same cycle.
        do_push  = push && !flush && ((count_q != CNT_FULL) || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            count_d = count_q + (do_push ? CNT_ONE : '0) - (do_pop ? CNT_ONE : '0);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the head is masked whenever the FIFO is empty.
    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

    assign head_data = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign count     = count_q;

endmodule
`default_nettype wire

// File: rtl/inst_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : inst_fetch_queue
//  Description : Instruction fetch stage. Owns the fetch PC, issues credit-
//                limited word reads to a variable-latency in-order memory and
//                buffers returned instructions for the decode stage. A
//                redirect flushes the queue and discards in-flight responses.
//  Ports       : clock, reset (async, active-low), bus (inst_fetch_queue_if
//                master: memory request/response, instruction handshake,
//                redirect), bubble_cnt (only with INST_FETCH_PERF_EN)
//  Options     : INST_FETCH_PERF_EN - adds a saturating empty-queue cycle
//                counter on output bubble_cnt
//  Revision    : 1.0 - initial release
// ============================================================================
module inst_fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic               clock,
    input  logic               reset,
    inst_fetch_queue_if.master bus
`ifdef INST_FETCH_PERF_EN
    ,
    output logic [31:0]        bubble_cnt
`endif
);
    localparam int unsigned      CNT_W        = $clog2(DEPTH) + 1;
    localparam logic [CNT_W:0]   CREDIT_LIMIT = (CNT_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    logic [31:0]      pc_q, pc_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] discard_q, discard_d;
    logic [CNT_W-1:0] q_count;
    logic [CNT_W-1:0] tag_count;
    logic [CNT_W:0]   in_use;
    logic             accept;
    logic             resp_take;
    logic             resp_keep;
    logic             pop;
    logic [31:0]      tag_pc;
    fetch_entry_t     push_entry;
    fetch_entry_t     head;

    always_comb begin
        // Credits see only registered occupancy; a same-cycle pop frees its
        // slot one cycle later.
        in_use        = {1'b0, q_count} + {1'b0, outstanding_q};
        bus.req_valid = reset && (in_use < CREDIT_LIMIT);
        bus.req_addr  = pc_q[31:2];
        accept        = bus.req_valid && bus.req_ready;
        // Responses with nothing outstanding (e.g. left over from before a
        // reset) are ignored.
        resp_take     = bus.resp_valid && (outstanding_q != '0);
        resp_keep     = resp_take && (discard_q == '0) && (tag_count != '0) && !bus.redirect;
        pop           = bus.inst_valid && bus.inst_ready && !bus.redirect;
        push_entry    = '{pc: tag_pc, inst: bus.resp_data};

        pc_d          = accept ? (pc_q + PC_INCR) : pc_q;
        outstanding_d = outstanding_q + (accept ? CNT_ONE : '0) - (resp_take ? CNT_ONE : '0);
        discard_d     = discard_q;
        if (bus.redirect) begin
            pc_d      = word_align(bus.redirect_pc);
            // Everything still in flight after this cycle is stale, including
            // a request accepted right now.
            discard_d = outstanding_d;
        end else if (resp_take && (discard_q != '0)) begin
            discard_d = discard_q - CNT_ONE;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_q          <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            pc_q          <= pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    // Tags of requests whose responses will be kept; stale tags are flushed on
    // redirect, so discarded responses never pop here.
    fetch_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clock     (clock),
        .reset     (reset),
        .flush     (bus.redirect),
        .push      (accept),
        .push_data (pc_q),
        .pop       (resp_keep),
        .head_data (tag_pc),
        .count     (tag_count)
    );

    fetch_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_inst_fifo (
        .clock     (clock),
        .reset     (reset),
        .flush     (bus.redirect),
        .push      (resp_keep),
        .push_data (push_entry),
        .pop       (pop),
        .head_data (head),
        .count     (q_count)
    );

    assign bus.inst_valid = (q_count != '0);
    assign bus.inst       = head.inst;
    assign bus.inst_pc    = head.pc;

`ifdef INST_FETCH_PERF_EN
    logic [31:0] bubble_cnt_q, bubble_cnt_d;

    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if (!bus.inst_valid && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
            bubble_cnt_d = bubble_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) bubble_cnt_q <= '0;
        else        bubble_cnt_q <= bubble_cnt_d;
    end

    assign bubble_cnt = bubble_cnt_q;
`endif

endmodule
`default_nettype wire
